// File: rtl/tdc_sweep_checker_pkg.sv
// Shared constants for the TDC sweep checker: geometry, widths, FSM encoding.
`ifndef NUM_TAPS
`define NUM_TAPS 240
`endif

package tdc_sweep_checker_pkg;

  localparam int unsigned NUM_TAPS = `NUM_TAPS;
  localparam int unsigned BIN_W    = 9;
  localparam int unsigned CNT_W    = 16;
  localparam int unsigned STEPS    = `NUM_TAPS;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_CLEAR   = 3'd1;
  localparam logic [2:0] ST_COLLECT = 3'd2;
  localparam logic [2:0] ST_SCAN    = 3'd3;
  localparam logic [2:0] ST_DONE    = 3'd4;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/tdc_hist_ram.sv
// Histogram storage: NUM_TAPS x CNT_W, one write port, one synchronous read port.
module tdc_hist_ram
  import tdc_sweep_checker_pkg::*;
(
  input  logic             clk,
  input  logic             we,
  input  logic [BIN_W-1:0] waddr,
  input  logic [CNT_W-1:0] wdata,
  input  logic [BIN_W-1:0] raddr,
  output logic [CNT_W-1:0] rdata
);

  logic [CNT_W-1:0] mem_q [NUM_TAPS];

  // Read-before-write array; addresses past the last bin write nothing and read 0.
  always_ff @(posedge clk) begin
    if (we && (waddr < BIN_W'(NUM_TAPS))) begin
      mem_q[waddr] <= wdata;
    end
    rdata <= (raddr < BIN_W'(NUM_TAPS)) ? mem_q[raddr] : '0;
  end

endmodule

// File: rtl/tdc_sweep_checker.sv
// Code-density histogram, monotonic check and missing-code scan of TDC sweep hits.
module tdc_sweep_checker
  import tdc_sweep_checker_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             tdc_valid,
  input  logic [BIN_W-1:0] tdc_bin,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] hits_total,
  output logic [CNT_W-1:0] viol_count,
  output logic [CNT_W-1:0] oor_count,
  output logic [BIN_W-1:0] missing_count,
  output logic [BIN_W-1:0] min_bin,
  output logic [BIN_W-1:0] max_bin,
  input  logic [BIN_W-1:0] rd_addr,
  output logic [CNT_W-1:0] rd_data
);

  logic [2:0]       state_q, state_d;
  logic [BIN_W-1:0] idx_q, idx_d;
  logic             stop_pend_q, stop_pend_d;
  logic             scan_vld_q, scan_vld_d;
  logic             s1_vld_q, s1_vld_d;
  logic [BIN_W-1:0] s1_bin_q, s1_bin_d;
  logic             fwd_vld_q, fwd_vld_d;
  logic [BIN_W-1:0] fwd_bin_q, fwd_bin_d;
  logic [CNT_W-1:0] fwd_data_q, fwd_data_d;
  logic [CNT_W-1:0] hits_q, hits_d, viol_q, viol_d, oor_q, oor_d;
  logic [BIN_W-1:0] missing_q, missing_d, min_q, min_d, max_q, max_d;
  logic [BIN_W-1:0] last_q, last_d, step_q, step_d;
  logic             busy_q, busy_d, done_q, done_d, rd_ok_q, rd_ok_d;

  logic             ram_we;
  logic [BIN_W-1:0] ram_waddr, ram_raddr;
  logic [CNT_W-1:0] ram_wdata, ram_rdata, old_cnt, new_cnt;
  logic             in_range, hit_acc, hit_oor;

  tdc_hist_ram u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .raddr (ram_raddr),
    .rdata (ram_rdata)
  );

  // Next-state, RAM port muxing, increment pipeline and statistics.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    stop_pend_d = stop_pend_q;
    scan_vld_d  = 1'b0;
    hits_d      = hits_q;
    viol_d      = viol_q;
    oor_d       = oor_q;
    missing_d   = missing_q;
    min_d       = min_q;
    max_d       = max_q;
    last_d      = last_q;
    step_d      = step_q;
    ram_raddr   = '0;
    hit_acc     = 1'b0;
    hit_oor     = 1'b0;
    in_range    = (tdc_bin < BIN_W'(NUM_TAPS));

    // Stage 2: the RAM read missed last cycle's write, so take that value when bins match.
    old_cnt     = (fwd_vld_q && (fwd_bin_q == s1_bin_q)) ? fwd_data_q : ram_rdata;
    new_cnt     = sat_inc(old_cnt);
    ram_we      = s1_vld_q;
    ram_waddr   = s1_bin_q;
    ram_wdata   = new_cnt;
    fwd_vld_d   = s1_vld_q;
    fwd_bin_d   = s1_bin_q;
    fwd_data_d  = new_cnt;
    s1_vld_d    = 1'b0;
    s1_bin_d    = tdc_bin;
    rd_ok_d     = (state_q == ST_DONE) && (rd_addr < BIN_W'(NUM_TAPS));

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_CLEAR;
          idx_d   = '0;
        end
      end
      ST_CLEAR: begin
        ram_we      = 1'b1;
        ram_waddr   = idx_q;
        ram_wdata   = '0;
        hits_d      = '0;
        viol_d      = '0;
        oor_d       = '0;
        missing_d   = '0;
        min_d       = '1;
        max_d       = '0;
        last_d      = '0;
        step_d      = '0;
        stop_pend_d = 1'b0;
        if (idx_q == BIN_W'(NUM_TAPS - 1)) begin
          state_d = ST_COLLECT;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + BIN_W'(1);
        end
      end
      ST_COLLECT: begin
        ram_raddr = tdc_bin;
        if (tdc_valid && !stop_pend_q) begin
          hit_acc = in_range;
          hit_oor = !in_range;
        end
        if (stop) begin
          stop_pend_d = 1'b1;
        end
        if (stop_pend_q && !s1_vld_q) begin
          state_d     = ST_SCAN;
          idx_d       = '0;
          stop_pend_d = 1'b0;
        end
      end
      ST_SCAN: begin
        ram_raddr = idx_q;
        if (scan_vld_q && (ram_rdata == '0)) begin
          missing_d = missing_q + BIN_W'(1);
        end
        if (idx_q == BIN_W'(NUM_TAPS)) begin
          state_d = ST_DONE;
        end else begin
          scan_vld_d = 1'b1;
          idx_d      = idx_q + BIN_W'(1);
        end
      end
      ST_DONE: begin
        ram_raddr = rd_addr;
        if (start) begin
          state_d = ST_CLEAR;
          idx_d   = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (hit_acc) begin
      s1_vld_d = 1'b1;
      hits_d   = sat_inc(hits_q);
      if (tdc_bin < min_q) min_d = tdc_bin;
      if (tdc_bin > max_q) max_d = tdc_bin;
      if ((step_q != '0) && (tdc_bin < last_q)) viol_d = sat_inc(viol_q);
      last_d = tdc_bin;
      step_d = (step_q == BIN_W'(STEPS - 1)) ? '0 : step_q + BIN_W'(1);
    end
    if (hit_oor) begin
      oor_d = sat_inc(oor_q);
    end

    busy_d = (state_d == ST_CLEAR) || (state_d == ST_COLLECT) || (state_d == ST_SCAN);
    done_d = (state_d == ST_DONE);
  end

  // State and statistics registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      stop_pend_q <= 1'b0;
      scan_vld_q  <= 1'b0;
      s1_vld_q    <= 1'b0;
      s1_bin_q    <= '0;
      fwd_vld_q   <= 1'b0;
      fwd_bin_q   <= '0;
      fwd_data_q  <= '0;
      hits_q      <= '0;
      viol_q      <= '0;
      oor_q       <= '0;
      missing_q   <= '0;
      min_q       <= '1;
      max_q       <= '0;
      last_q      <= '0;
      step_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      rd_ok_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      stop_pend_q <= stop_pend_d;
      scan_vld_q  <= scan_vld_d;
      s1_vld_q    <= s1_vld_d;
      s1_bin_q    <= s1_bin_d;
      fwd_vld_q   <= fwd_vld_d;
      fwd_bin_q   <= fwd_bin_d;
      fwd_data_q  <= fwd_data_d;
      hits_q      <= hits_d;
      viol_q      <= viol_d;
      oor_q       <= oor_d;
      missing_q   <= missing_d;
      min_q       <= min_d;
      max_q       <= max_d;
      last_q      <= last_d;
      step_q      <= step_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      rd_ok_q     <= rd_ok_d;
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign hits_total    = hits_q;
  assign viol_count    = viol_q;
  assign oor_count     = oor_q;
  assign missing_count = missing_q;
  assign min_bin       = min_q;
  assign max_bin       = max_q;
  assign rd_data       = rd_ok_q ? ram_rdata : '0;

endmodule

// File: tb/tb_tdc_sweep_checker.sv
// Directed bench for tdc_sweep_checker with a reference model and expectation queue.
module tb_tdc_sweep_checker;
  import tdc_sweep_checker_pkg::*;

  logic             clk = 1'b0;
  logic             rst, start, stop, tdc_valid;
  logic [BIN_W-1:0] tdc_bin, rd_addr;
  logic             busy, done;
  logic [CNT_W-1:0] hits_total, viol_count, oor_count, rd_data;
  logic [BIN_W-1:0] missing_count, min_bin, max_bin;

  always #5 clk = ~clk;

  tdc_sweep_checker dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .stop          (stop),
    .tdc_valid     (tdc_valid),
    .tdc_bin       (tdc_bin),
    .busy          (busy),
    .done          (done),
    .hits_total    (hits_total),
    .viol_count    (viol_count),
    .oor_count     (oor_count),
    .missing_count (missing_count),
    .min_bin       (min_bin),
    .max_bin       (max_bin),
    .rd_addr       (rd_addr),
    .rd_data       (rd_data)
  );

  int          n_checks = 0;
  int          n_pass   = 0;
  int          n_fail   = 0;
  string       tag_q[$];
  int unsigned exp_q[$];

  int unsigned m_hist [NUM_TAPS];
  int unsigned m_hits, m_viol, m_oor, m_min, m_max, m_last, m_step;

  task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic sb_push(input string tag, input int unsigned v);
    tag_q.push_back(tag);
    exp_q.push_back(v);
  endtask

  task automatic sb_pop(input int unsigned obs);
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $error("FAIL scoreboard_empty: observed %0d expected none", obs);
    end else begin
      check(tag_q.pop_front(), obs, exp_q.pop_front());
    end
  endtask

  function automatic int unsigned sat(input int unsigned v);
    return (v < 65535) ? v + 1 : 65535;
  endfunction

  task automatic model_clear();
    foreach (m_hist[i]) m_hist[i] = 0;
    m_hits = 0; m_viol = 0; m_oor = 0;
    m_min = 511; m_max = 0; m_last = 0; m_step = 0;
  endtask

  task automatic model_hit(input int unsigned b);
    if (b >= NUM_TAPS) begin
      m_oor = sat(m_oor);
    end else begin
      m_hits    = sat(m_hits);
      m_hist[b] = sat(m_hist[b]);
      if (m_step != 0 && b < m_last) m_viol = sat(m_viol);
      m_last = b;
      m_step = (m_step == STEPS - 1) ? 0 : m_step + 1;
      if (b < m_min) m_min = b;
      if (b > m_max) m_max = b;
    end
  endtask

  task automatic hit(input int unsigned b, input bit with_stop);
    tdc_valid = 1'b1;
    tdc_bin   = BIN_W'(b);
    stop      = with_stop;
    model_hit(b);
    @(negedge clk);
    tdc_valid = 1'b0;
    stop      = 1'b0;
  endtask

  task automatic run_begin(input string name);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    model_clear();
    repeat (242) @(negedge clk);
    check({name, "_busy_collect"}, busy, 1);
  endtask

  task automatic end_sweep(input string name, input bit send_stop);
    int unsigned miss;
    int          cyc;
    if (send_stop) begin
      stop = 1'b1;
      @(negedge clk);
      stop = 1'b0;
    end
    miss = 0;
    foreach (m_hist[i]) if (m_hist[i] == 0) miss++;
    sb_push({name, "_hits_total"}, m_hits);
    sb_push({name, "_viol_count"}, m_viol);
    sb_push({name, "_oor_count"}, m_oor);
    sb_push({name, "_missing_count"}, miss);
    sb_push({name, "_min_bin"}, m_min);
    sb_push({name, "_max_bin"}, m_max);
    cyc = 0;
    while (!done && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    check({name, "_done"}, done, 1);
    sb_pop(hits_total);
    sb_pop(viol_count);
    sb_pop(oor_count);
    sb_pop(missing_count);
    sb_pop(min_bin);
    sb_pop(max_bin);
  endtask

  task automatic read_bin(input int unsigned a);
    rd_addr = BIN_W'(a);
    sb_push($sformatf("rd_data[%0d]", a), (a < NUM_TAPS) ? m_hist[a] : 0);
    @(negedge clk);
    sb_pop(rd_data);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; tdc_valid = 1'b0;
    tdc_bin = '0; rd_addr = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_hits", hits_total, 0);
    check("reset_viol", viol_count, 0);
    check("reset_oor", oor_count, 0);
    check("reset_missing", missing_count, 0);
    check("reset_min", min_bin, 511);
    check("reset_max", max_bin, 0);
    check("reset_rd_data", rd_data, 0);

    // Ideal sweep
    run_begin("ideal");
    for (int b = 0; b < NUM_TAPS; b++) hit(b, 1'b0);
    end_sweep("ideal", 1'b1);
    for (int a = 0; a < NUM_TAPS; a++) read_bin(a);
    read_bin(300);

    // Three sweeps with bin 100 dead
    run_begin("dead");
    for (int s = 0; s < 3; s++)
      for (int b = 0; b < NUM_TAPS; b++) hit((b == 100) ? 101 : b, 1'b0);
    end_sweep("dead", 1'b1);
    for (int a = 99; a <= 102; a++) read_bin(a);

    // Back-to-back same bin, then alternating bins
    run_begin("b2b");
    for (int i = 0; i < 5; i++) hit(7, 1'b0);
    hit(20, 1'b0); hit(21, 1'b0); hit(20, 1'b0); hit(21, 1'b0);
    end_sweep("b2b", 1'b1);
    read_bin(7); read_bin(20); read_bin(21); read_bin(8);

    // Violation, out-of-range, and a hit coinciding with stop
    run_begin("viol");
    hit(10, 1'b0); hit(12, 1'b0); hit(11, 1'b0); hit(250, 1'b0);
    hit(13, 1'b1);
    end_sweep("viol", 1'b0);
    read_bin(13); read_bin(11);

    // Saturation
    run_begin("sat");
    for (int i = 0; i < 70000; i++) hit(0, i == 69999);
    end_sweep("sat", 1'b0);
    read_bin(0); read_bin(1);

    // Reset during collection, then a clean run
    run_begin("abort");
    for (int b = 200; b <= 210; b++) hit(b, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_hits", hits_total, 0);
    rst = 1'b0;
    @(negedge clk);
    run_begin("rerun");
    hit(5, 1'b0); hit(6, 1'b0); hit(7, 1'b0);
    end_sweep("rerun", 1'b1);
    read_bin(200); read_bin(205); read_bin(5);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/tdc_sweep_checker.md
Name: tdc_sweep_checker

Overview:
- Receiving end of the debug-hit sweep: consumes encoded TDC fine-time bins produced while the debug pulse generator sweeps hit positions across the tapped delay line.
- Builds a per-bin code-density histogram, checks per-sweep monotonicity, and reports missing codes and bin extremes.
- Sits after the thermometer-to-binary encoder; results are read back over a simple synchronous read port.

Parameters:
- NUM_TAPS, `NUM_TAPS (240), number of delay-line bins; valid bins are 0..NUM_TAPS-1.
- BIN_W, 9, width of the bin index.
- CNT_W, 16, width of histogram words and all statistic counters.
- STEPS, `NUM_TAPS, hits per sweep; the monotonic check restarts after this many hits.

Ports:
- clk  in  1  system clock
- rst  in  1  reset
- start  in  1  one-cycle pulse; begins clear then collect
- stop  in  1  one-cycle pulse (tie to generator finished rising edge); ends collect
- tdc_valid  in  1  qualifies tdc_bin
- tdc_bin  in  BIN_W  encoded fine-time bin
- busy  out  1  high in CLEAR, COLLECT and SCAN
- done  out  1  high in DONE until next start
- hits_total  out  CNT_W  accepted hits, saturating
- viol_count  out  CNT_W  monotonicity violations, saturating
- oor_count  out  CNT_W  hits with tdc_bin >= NUM_TAPS, saturating
- missing_count  out  BIN_W  bins with zero hits, valid when done
- min_bin  out  BIN_W  smallest accepted bin
- max_bin  out  BIN_W  largest accepted bin
- rd_addr  in  BIN_W  histogram read address
- rd_data  out  CNT_W  histogram word; one-cycle latency; valid only when done

Behaviour:
- Reset rst, synchronous, active-high; clock clk.
- Reset values: state IDLE; busy, done, all counters, missing_count and max_bin 0; min_bin all-ones; rd_data 0. Histogram contents are undefined after reset; CLEAR initializes them.
- States and transitions:
  - IDLE -> CLEAR on start.
  - CLEAR: writes 0 to addresses 0..NUM_TAPS-1, one per cycle, NUM_TAPS cycles; also zeroes counters and the step index, and sets min_bin to all-ones and max_bin to 0. Then -> COLLECT.
  - COLLECT: accepts tdc_valid. On stop, -> SCAN once the increment pipeline has drained (at most 2 cycles).
  - SCAN: reads every bin once, NUM_TAPS cycles; missing_count = number of zero words. Then -> DONE.
  - DONE -> CLEAR on start.
- start in CLEAR, COLLECT or SCAN is ignored. stop outside COLLECT is ignored.
- Accepted hit: tdc_valid in COLLECT with tdc_bin < NUM_TAPS.
  - An out-of-range hit increments only oor_count; it does not advance the step index.
- Histogram increment is a 2-stage read-modify-write. Stage 1 reads; stage 2 writes old+1, saturating at all-ones.
  - Back-to-back hits to the same bin must forward the stage-2 result, so no count is lost at a 1-hit/cycle rate.
- Monotonic check:
  - The step index counts accepted hits 0..STEPS-1, then wraps to 0.
  - At index 0 the last-bin register loads without checking.
  - Otherwise tdc_bin < last_bin increments viol_count; last_bin always updates.
- min_bin and max_bin update combinationally-compared, registered on each accepted hit.
- All counters saturate at all-ones and never wrap.
- A hit arriving in the same cycle as stop is accepted.
- rd_port: rd_data is driven from rd_addr only in DONE and is 0 otherwise. rd_addr >= NUM_TAPS returns 0.
- Reset mid-operation: returns to IDLE in the next cycle; results are discarded.

Decomposition:
- Shared defines: NUM_TAPS (existing), the state encoding constants and CNT_W.
- One sub-module, tdc_hist_ram: simple dual-port RAM, NUM_TAPS x CNT_W, synchronous read, one write port, inferable as block RAM.
- The FSM, forwarding logic and statistics stay in tdc_sweep_checker.

Test Plan:
1. Ideal sweep.
   - Stimulus: start; after 240 cycles feed bins 0..239 once each; stop.
   - Required response: hits_total=240, viol_count=0, missing_count=0, min_bin=0, max_bin=239, every rd_data=1.
2. Three sweeps with bin 100 dead.
   - Stimulus: 3 sweeps of 0..239, with 100 replaced by 101.
   - Required response: missing_count=1, rd_data[100]=0, rd_data[101]=6, viol_count=0 (sweep wrap is not a violation).
3. Back-to-back same bin.
   - Stimulus: 5 consecutive valid cycles with bin 7.
   - Required response: rd_data[7]=5, no lost counts.
4. Violation and out-of-range.
   - Stimulus: sequence 10, 12, 11, 250, 13.
   - Required response: viol_count=1, oor_count=1, hits_total=4, min_bin=10, max_bin=13.
5. Saturation.
   - Stimulus: 70000 hits to bin 0.
   - Required response: rd_data[0]=16'hFFFF, hits_total=16'hFFFF, no wrap.
6. Reset mid-COLLECT.
   - Stimulus: assert rst during hits, then start again.
   - Required response: busy=0 and done=0 the cycle after reset; next run's statistics show no residue from the aborted run.
